vnu_serial: RTL
===============

# vnu_serial

Serial variable-node update unit for the min-sum LDPC reconciliation decoder. For one variable node it takes a channel LLR plus up to MAX_DEG check-to-variable messages, one per cycle, in signed Q(INT.FRAC) two's complement. It accumulates them with saturating addition, then streams out one extrinsic variable-to-check message per edge (total minus that edge's message, saturated) and the node's hard decision. It sits between the check-node message memory (upstream) and the check-node units (downstream).

## Interface
- INT, 8, integer bits including sign
- FRAC, 8, fractional bits; word width W = INT+FRAC
- MAX_DEG, 8, maximum variable-node degree (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- llr_in  in  W  channel LLR
- llr_valid  in  1  llr_in valid
- msg_in  in  W  incoming check-to-variable message
- msg_valid  in  1  msg_in valid
- msg_last  in  1  marks final message of this node
- in_ready  out  1  input handshake ready (shared by llr and msg)
- ext_out  out  W  extrinsic variable-to-check message
- ext_valid  out  1  ext_out valid
- ext_last  out  1  final extrinsic of this node
- ext_ready  in  1  downstream accepts ext_out
- hard_bit  out  1  sign of total (1 = negative); valid while ext_valid
- deg_err  out  1  sticky: MAX_DEG messages arrived without msg_last

## Operation
- States: IDLE, ACCUM, EMIT.
- IDLE: in_ready=1. Only llr_valid is accepted; msg_valid is ignored. On accept: total←llr_in, cnt←0, go to ACCUM.
- ACCUM: in_ready=1. Only msg_valid is accepted; llr_valid is ignored. On accept: buf[cnt]←msg_in, total←sat_add(total,msg_in), cnt←cnt+1.
  - If msg_last: deg←cnt+1, idx←0, go to EMIT.
  - If cnt+1 == MAX_DEG without msg_last: set deg_err, deg←MAX_DEG, go to EMIT.
- EMIT: in_ready=0, ext_valid=1, ext_out=sat_sub(total,buf[idx]), ext_last=(idx==deg-1), hard_bit=total[W-1].
  - On ext_valid&&ext_ready: idx←idx+1. If ext_last, go to IDLE.
- sat_add: W-bit sum. Same-sign operands whose sum flips sign clamp to 0x7FFF (positive) or 0x8000 (negative).
- sat_sub: computed in W+1 bits, then clamped to [0x8000, 0x7FFF]. 0x8000 as subtrahend must not wrap.
- Accumulation is sequential with saturation at each step. Extrinsic results therefore do not undo earlier clamping; this is accepted.
- A msg_last on the first message gives degree 1.
- deg_err is cleared only by rst.

## Timing
- Reset values: state=IDLE, in_ready=1, ext_valid=0, ext_last=0, ext_out=0, hard_bit=0, deg_err=0, total=0, cnt=0, idx=0.
- All state and data are registered. ext_out, ext_last and hard_bit are combinational from registers only; there is no input-to-output combinational path.
- Latency: first ext_valid is asserted in the cycle after the msg_last handshake. Then one extrinsic per cycle under continuous ext_ready.
- Node throughput: 1 + deg + deg cycles.
- Backpressure: while ext_valid && !ext_ready, ext_out, ext_last and hard_bit hold stable.
- After the final ext handshake, in_ready=1 in the next cycle (IDLE). There is no overlap between nodes.
- rst asserted in any state returns to reset values at the next edge. Partial node data is discarded.

## Structure
- Shared package vnu_pkg: W, the saturation constants SAT_POS=0x7FFF and SAT_NEG=0x8000 (derived from W), and the state encoding.
- Sub-modules:
  - Accumulator: the existing sat_adder, unchanged.
  - Extrinsic path: one new combinational sub-module sat_sub (W-bit saturating subtractor).
- buf is a MAX_DEG×W register array. cnt, idx and deg are $clog2(MAX_DEG+1) bits.

## Test plan
- llr 0x0100, msgs 0x0200, 0x0300(last) -> ext 0x0400, 0x0300; hard_bit 0; ext_last on second; first ext_valid one cycle after last accept.
- Positive saturation: llr 0x7000, msgs 0x7000, 0x1000(last) -> total 0x7FFF; ext 0x0FFF, 0x6FFF.
- Negative saturation: llr 0x8100, msg 0x8000(last) -> total 0x8000; ext 0x0000; hard_bit 1. msg 0x0000 with total 0x8000 -> ext 0x8000.
- Backpressure: ext_ready low for 3 cycles mid-stream -> ext_out and ext_last hold; no message skipped or duplicated; in_ready stays 0.
- Degree overflow: MAX_DEG=8 messages of 0x0100 with no msg_last -> deg_err=1; 8 extrinsics of llr+0x0700; next node processes normally with deg_err still 1.
- Reset mid-EMIT (idx=1) -> next cycle: ext_valid=0, in_ready=1, deg_err=0. A new node then completes correctly.

Source files
------------

// File: rtl/vnu_pkg.sv
// Shared definitions for the serial variable-node update unit.
// Holds the default word format (Q8.8), the saturation limits for that
// word width and the controller state encoding.
package vnu_pkg;

  localparam int INT_BITS  = 8;
  localparam int FRAC_BITS = 8;
  localparam int W         = INT_BITS + FRAC_BITS;

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_adder.sv
// W-bit two's complement saturating adder (combinational).
// Ports:
//   i_a, i_b : signed operands
//   o_sum    : a+b, clamped to the most positive/negative word when
//              two same-sign operands produce a result of the other sign
import vnu_pkg::*;

module sat_adder #(
  parameter int W = vnu_pkg::W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  localparam logic [W-1:0] L_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] L_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] w_raw;
  logic         w_ovf;

  always_comb begin
    w_raw = i_a + i_b;
    w_ovf = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
    o_sum = w_ovf ? (i_a[W-1] ? L_NEG : L_POS) : w_raw;
  end

endmodule

// File: rtl/sat_sub.sv
// W-bit two's complement saturating subtractor (combinational).
// Ports:
//   i_a    : minuend
//   i_b    : subtrahend (the most negative word is handled without wrap)
//   o_diff : a-b, clamped to the most positive/negative word
import vnu_pkg::*;

module sat_sub #(
  parameter int W = vnu_pkg::W
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff
);

  localparam logic [W-1:0] L_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] L_NEG = {1'b1, {(W-1){1'b0}}};

  logic [W:0] w_wide;

  // One guard bit makes the true difference exact; the top two bits
  // disagreeing means it does not fit in W bits.
  always_comb begin
    w_wide = {i_a[W-1], i_a} - {i_b[W-1], i_b};
    if (w_wide[W] != w_wide[W-1]) begin
      o_diff = w_wide[W] ? L_NEG : L_POS;
    end else begin
      o_diff = w_wide[W-1:0];
    end
  end

endmodule

// File: rtl/vnu_serial.sv
// Serial variable-node update unit for the min-sum LDPC decoder.
// Takes one channel LLR then up to MAX_DEG check-to-variable messages,
// accumulates them with saturation, then emits one extrinsic message
// per edge (total minus that edge's message) plus the hard decision.
//
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_llr_in/_valid     : channel LLR, accepted only in IDLE
//   i_msg_in/_valid/_last : C2V messages, accepted only in ACCUM
//   o_in_ready          : shared input ready (IDLE and ACCUM)
//   o_ext_out/_valid/_last, i_ext_ready : extrinsic output stream
//   o_hard_bit          : sign of the node total, valid with o_ext_valid
//   o_deg_err           : sticky, MAX_DEG messages seen without last
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for the channel LLR of the next node
// ST_ACCUM | collecting C2V messages into buf and the running total
// ST_EMIT  | streaming total - buf[idx] for idx = 0 .. deg-1
import vnu_pkg::*;

module vnu_serial #(
  parameter int INT     = vnu_pkg::INT_BITS,
  parameter int FRAC    = vnu_pkg::FRAC_BITS,
  parameter int MAX_DEG = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INT+FRAC-1:0]   i_llr_in,
  input  logic                  i_llr_valid,
  input  logic [INT+FRAC-1:0]   i_msg_in,
  input  logic                  i_msg_valid,
  input  logic                  i_msg_last,
  output logic                  o_in_ready,
  output logic [INT+FRAC-1:0]   o_ext_out,
  output logic                  o_ext_valid,
  output logic                  o_ext_last,
  input  logic                  i_ext_ready,
  output logic                  o_hard_bit,
  output logic                  o_deg_err
);

  localparam int WL = INT + FRAC;
  localparam int CW = $clog2(MAX_DEG + 1);
  localparam int IW = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [WL-1:0]   r_buf [MAX_DEG];
  logic [WL-1:0]   r_total;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_idx;
  logic [CW-1:0]   r_deg;
  logic            r_deg_err;

  logic            w_acc_llr;
  logic            w_acc_msg;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_deg_full;
  logic            w_ext_last;
  logic            w_ext_hs;
  logic [WL-1:0]   w_sum;
  logic [WL-1:0]   w_diff;
  logic [WL-1:0]   w_buf_sel;

  assign w_acc_llr  = (r_state == ST_IDLE)  && i_llr_valid;
  assign w_acc_msg  = (r_state == ST_ACCUM) && i_msg_valid;
  assign w_cnt_inc  = r_cnt + CW'(1);
  assign w_deg_full = (w_cnt_inc == CW'(MAX_DEG));
  assign w_ext_last = (r_idx == (r_deg - CW'(1)));
  assign w_ext_hs   = (r_state == ST_EMIT) && i_ext_ready;
  assign w_buf_sel  = r_buf[r_idx[IW-1:0]];

  sat_adder #(.W(WL)) u_sat_adder (
    .i_a   (r_total),
    .i_b   (i_msg_in),
    .o_sum (w_sum)
  );

  sat_sub #(.W(WL)) u_sat_sub (
    .i_a    (r_total),
    .i_b    (w_buf_sel),
    .o_diff (w_diff)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_acc_llr) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_acc_msg && (i_msg_last || w_deg_full)) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_ext_hs && w_ext_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: registers only, gated so they read zero outside EMIT.
  always_comb begin
    o_in_ready  = 1'b0;
    o_ext_valid = 1'b0;
    o_ext_out   = '0;
    o_ext_last  = 1'b0;
    o_hard_bit  = 1'b0;
    o_deg_err   = r_deg_err;
    case (r_state)
      ST_IDLE, ST_ACCUM: o_in_ready = 1'b1;
      ST_EMIT: begin
        o_ext_valid = 1'b1;
        o_ext_out   = w_diff;
        o_ext_last  = w_ext_last;
        o_hard_bit  = r_total[WL-1];
      end
      default: o_in_ready = 1'b0;
    endcase
  end

  // Node datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_total   <= '0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_deg     <= '0;
      r_deg_err <= 1'b0;
    end else begin
      if (w_acc_llr) begin
        r_total <= i_llr_in;
        r_cnt   <= '0;
      end
      if (w_acc_msg) begin
        r_total <= w_sum;
        r_cnt   <= w_cnt_inc;
        if (i_msg_last) begin
          r_deg <= w_cnt_inc;
          r_idx <= '0;
        end else if (w_deg_full) begin
          r_deg_err <= 1'b1;
          r_deg     <= CW'(MAX_DEG);
          r_idx     <= '0;
        end
      end
      if (w_ext_hs) begin
        r_idx <= r_idx + CW'(1);
      end
    end
  end

  // Message store needs no reset: entries are always written before read.
  always_ff @(posedge i_clk) begin
    if (w_acc_msg) begin
      r_buf[r_cnt[IW-1:0]] <= i_msg_in;
    end
  end

endmodule
